// File: rtl/button_input_pkg.sv
// Shared constants for the dino push-button peripheral: register word addresses
// and EDGE register bit positions.
package dino_button_pkg;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_EDGE   = 2'd1;
   localparam logic [1:0] ADDR_MASK   = 2'd2;
   localparam logic [1:0] ADDR_COUNT  = 2'd3;

   localparam int unsigned EDGE_PRESS   = 0;
   localparam int unsigned EDGE_RELEASE = 1;

endpackage

// File: rtl/button_input_if.sv
// Avalon-MM slave bus plus interrupt line of the push-button peripheral.
interface button_input_if;

   logic [1:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic        irq;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata, irq
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata, irq
   );

endinterface

// File: rtl/button_input_debouncer.sv
// Two-flop synchroniser followed by a counting debouncer; emits the accepted level
// and one-cycle pulses on the edge where a new level is accepted.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_button,
   output logic o_stable,
   output logic o_rise_pulse,
   output logic o_fall_pulse
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_stable;
   logic [CntW-1:0] r_cnt;
   logic            w_diff;
   logic            w_done;

   assign w_diff = r_sync2 ^ r_stable;
   assign w_done = w_diff && (r_cnt == CntMax);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_button;
         r_sync2 <= r_sync1;
         // Any return to the accepted level restarts qualification from zero.
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_done) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_stable     = r_stable;
   assign o_rise_pulse = w_done & r_sync2;
   assign o_fall_pulse = w_done & ~r_sync2;

endmodule

// File: rtl/button_input.sv
// Push-button Avalon-MM slave: debounced level, W1C edge flags, press counter,
// interrupt mask and a registered level interrupt.
module button_input
   import dino_button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           button_in,
   button_input_if.slave  bus
);

   logic             w_stable;
   logic             w_rise;
   logic             w_fall;
   logic             w_wr_edge;
   logic             w_wr_mask;
   logic             w_wr_count;
   logic [1:0]       w_edge_d;
   logic [CNT_W-1:0] w_count_d;
   logic [31:0]      w_rdata;
   logic             w_unused_wdata;

   logic [1:0]       r_edge;
   logic [1:0]       r_mask;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_readdata;
   logic             r_irq;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk          (clk),
      .reset        (reset),
      .i_button     (button_in),
      .o_stable     (w_stable),
      .o_rise_pulse (w_rise),
      .o_fall_pulse (w_fall)
   );

   assign w_wr_edge  = bus.avs_write && (bus.avs_address == ADDR_EDGE);
   assign w_wr_mask  = bus.avs_write && (bus.avs_address == ADDR_MASK);
   assign w_wr_count = bus.avs_write && (bus.avs_address == ADDR_COUNT);
   assign w_unused_wdata = ^bus.avs_writedata[31:2];

   always_comb begin
      w_edge_d = r_edge;
      if (w_wr_edge) w_edge_d = w_edge_d & ~bus.avs_writedata[1:0];
      // Hardware set is applied after the clear so a colliding event is kept.
      if (w_rise) w_edge_d[EDGE_PRESS] = 1'b1;
      if (w_fall) w_edge_d[EDGE_RELEASE] = 1'b1;

      w_count_d = r_count;
      if (w_rise) begin
         w_count_d = w_wr_count ? CNT_W'(1) : r_count + 1'b1;
      end else if (w_wr_count) begin
         w_count_d = '0;
      end

      w_rdata = '0;
      unique case (bus.avs_address)
         ADDR_STATUS: w_rdata[0]   = w_stable;
         ADDR_EDGE:   w_rdata[1:0] = r_edge;
         ADDR_MASK:   w_rdata[1:0] = r_mask;
         ADDR_COUNT:  w_rdata      = 32'(r_count);
         default:     w_rdata      = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_edge     <= '0;
         r_mask     <= '0;
         r_count    <= '0;
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_edge  <= w_edge_d;
         r_count <= w_count_d;
         r_irq   <= |(r_edge & r_mask);
         if (w_wr_mask) r_mask <= bus.avs_writedata[1:0];
         if (bus.avs_read) r_readdata <= w_rdata;
      end
   end

   assign bus.avs_readdata = r_readdata;
   assign bus.irq          = r_irq;

endmodule

// File: doc/button_input.md
Name: button_input

Overview:
- Avalon-MM slave peripheral that receives the active-high user push-button conduit into the dino system.
- It is the input-direction counterpart of the seg7 display output peripheral.
- Synchronises and debounces the raw button, captures press and release edges, counts presses, and raises a level interrupt for the Nios game loop.
- Sits inside the system interconnect; its conduit is the system's button export.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (20 ms at 50 MHz); must be at least 2.
- CNT_W, 16, width of the press counter.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- avs_address  in  2  register word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, fixed read latency 1
- irq  out  1  level interrupt, active-high
- button_in  in  1  raw asynchronous button level, 1 = pressed

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high.
- Reset values:
  - avs_readdata = 0, irq = 0.
  - Synchroniser flops = 0, stable = 0, debounce counter = 0.
  - EDGE = 0, MASK = 0, COUNT = 0.
- Synchroniser:
  - button_in passes through two flops to give sync.
  - sync must not be used anywhere else.
- Debouncer (state IDLE/COUNTING, implied by counter):
  - sync == stable: counter <= 0.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles resets the count and is discarded.
  - Latency from a button_in change to a stable change is exactly 2 + DEBOUNCE_CYCLES rising edges.
- Event capture (same clock edge as the stable update):
  - Rising stable sets EDGE[0] (press) and increments COUNT, which wraps 2^CNT_W-1 to 0.
  - Falling stable sets EDGE[1] (release).
- Register map (word addresses):
  - 0 STATUS, RO: bit0 = stable.
  - 1 EDGE, W1C: bits[1:0].
  - 2 MASK, RW: bits[1:0].
  - 3 COUNT, RO data; any write clears it to 0.
  - Unused bits read 0.
- Reads:
  - avs_readdata is registered and valid the cycle after avs_read.
  - avs_readdata holds its value when no read is issued.
  - Reads have no side effects.
- Simultaneous events:
  - An edge set and a W1C clear of the same bit in one cycle: set wins, bit = 1.
  - A COUNT write and a press in the same cycle: COUNT = 1.
  - avs_read and avs_write together: both are performed; read returns the pre-write value.
- irq = |(EDGE & MASK), driven from registered state only (no combinational path from the bus); updates one cycle after the EDGE/MASK register change.
- Reset mid-debounce: counter and stable return to 0; a button still held re-qualifies after 2 + DEBOUNCE_CYCLES cycles and counts as a new press.

Decomposition:
- Package dino_button_pkg holds:
  - Register address constants: ADDR_STATUS=0, ADDR_EDGE=1, ADDR_MASK=2, ADDR_COUNT=3.
  - Bit indices: EDGE_PRESS=0, EDGE_RELEASE=1.
- Sub-module button_debouncer (params DEBOUNCE_CYCLES):
  - Contains the synchroniser and debouncer.
  - Outputs stable, rise_pulse and fall_pulse, each pulse one cycle wide.
  - The top level holds the registers, bus decode and irq.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4: button_in 0->1 at edge 0, held -> STATUS bit0 = 1 from edge 6, EDGE = 0x1, COUNT = 1; irq stays 0 while MASK = 0.
- Glitch rejection: button_in high for 3 cycles then low -> stable never changes; EDGE = 0 and COUNT = 0 after 20 cycles.
- Interrupt and W1C: MASK = 0x3, then press and release -> EDGE = 0x3 and irq = 1; write EDGE = 0x1 -> EDGE = 0x2, irq stays 1; write 0x2 -> irq = 0 one cycle later.
- Set-wins collision: issue the EDGE write of 0x1 on the exact edge the press qualifies -> EDGE[0] = 1 and irq remains asserted.
- Counter wrap and clear, CNT_W=4: 16 presses -> COUNT = 0; one more press -> 1; write COUNT in the qualifying cycle of a press -> COUNT = 1.
- Reset mid-operation: assert reset for 1 cycle during a held press with counter = 2 -> all registers read 0; press recognised 6 cycles after reset deasserts, COUNT = 1.
